mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares one single-port `memory2c` instance between the instruction-fetch port and the data load/store port of the RISC-V core.
- Replaces the separate imem/dmem pair with one arbitrated memory.
- Sequences each access through a small FSM and holds the winner's address and data stable for the full memory latency.
- Returns read data with a one-cycle valid pulse; uses fixed data-over-fetch priority with a fetch starvation guard.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- MEM_LAT, 1, number of ACCESS cycles per transaction (memory read latency); legal range 1..15.
- STARVE_MAX, 4, number of consecutive data grants after which a waiting fetch wins; legal range 1..15.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- if_req  in  1  fetch request; level, sampled only in IDLE.
- if_addr  in  ADDR_W  fetch address.
- if_gnt  out  1  fetch transaction in ACCESS.
- if_rdata  out  DATA_W  fetch read data, registered.
- if_valid  out  1  one-cycle fetch completion pulse.
- d_req  in  1  data request; level, sampled only in IDLE.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  ADDR_W  data address.
- d_wdata  in  DATA_W  store data.
- d_gnt  out  1  data transaction in ACCESS.
- d_rdata  out  DATA_W  load data, registered.
- d_valid  out  1  one-cycle data completion pulse (loads and stores).
- mem_en  out  1  memory enable.
- mem_wr  out  1  memory write strobe.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data.

Behaviour:
- Reset (asynchronous, effective immediately):
  - State goes to IDLE.
  - All outputs go to 0, including the rdata registers.
  - Latched address/data/we are cleared, the wait counter is cleared and the starve counter is cleared.
  - Any in-flight access is discarded and produces no valid pulse. mem_en/mem_wr drop in the same cycle rst rises.
- States: IDLE, ACCESS.
- IDLE:
  - mem_en=0 and both gnt=0.
  - If any request is present at the rising edge, latch the winner's addr, we and wdata and the winner id, then go to ACCESS.
  - If no request is present, stay in IDLE.
- Arbitration, evaluated at the IDLE edge:
  - Only d_req: data wins. Only if_req: fetch wins.
  - Both present: data wins unless starve_cnt == STARVE_MAX, in which case fetch wins.
  - starve_cnt increments when data wins while if_req=1. It clears when fetch wins or when if_req=0 at an arbitration edge. It saturates at STARVE_MAX.
- ACCESS, lasting exactly MEM_LAT cycles, counted by the wait counter:
  - mem_en=1 and mem_addr = latched addr.
  - mem_wr = latched we. Fetch transactions always have we=0.
  - mem_wdata = latched wdata. Data is 0 for fetch transactions.
  - The winner's gnt=1 throughout ACCESS.
  - Requester inputs are ignored during ACCESS.
- Completion, at the edge ending the last ACCESS cycle:
  - For a load or fetch, register mem_rdata into the winner's rdata. For a store, the winner's rdata holds its previous value.
  - The winner's valid goes to 1 for exactly one cycle.
  - State returns to IDLE.
- Latency: a request sampled at edge E gives ACCESS in cycles E+1..E+MEM_LAT and valid in cycle E+MEM_LAT+1. With MEM_LAT=1, valid appears 2 cycles after the request is sampled.
- Back-to-back:
  - The valid cycle is an IDLE cycle, so a request still asserted then is arbitrated at that edge.
  - Peak throughput is one access per MEM_LAT+1 cycles.
  - A requester that wants no further access deasserts req in its valid cycle.
- rdata registers hold their value until overwritten by a new completion or by reset.
- Outputs are never X after reset. if_gnt and d_gnt are never both 1, and if_valid and d_valid are never both 1.

Decomposition:
- Shared package `riscv_mem_pkg`:
  - State encoding (IDLE=1'b0, ACCESS=1'b1).
  - Requester id constants (REQ_IF=1'b0, REQ_D=1'b1).
  - Default MEM_LAT and STARVE_MAX.
- One sub-module, `mem_arb_pick`: the priority decision plus the starve counter register. It takes clk, rst, if_req, d_req and an arb_edge enable, and outputs the winner id.

Test Plan:
- Assert rst during cycle 1 of a data ACCESS -> mem_en, d_gnt and d_valid are 0 immediately. After release with no requests, the block stays in IDLE and all outputs stay 0.
- if_req=1, if_addr=0x100, mem_rdata=0x00500093, MEM_LAT=1 -> mem_addr=0x100 and mem_en=1 in cycle 1. if_valid=1 in cycle 2 only, with if_rdata=0x00500093.
- if_req and d_req (load 0x2000) both asserted at edge 0, held until their own valid -> d_gnt in cycle 1, d_valid in cycle 2. if_gnt in cycle 3, if_valid in cycle 4. Never two grants at once.
- Store d_we=1, d_addr=0x40, d_wdata=0xDEADBEEF, with d_rdata previously 0x11 -> mem_wr=1, mem_addr=0x40, mem_wdata=0xDEADBEEF for exactly one cycle. d_valid pulses once and d_rdata stays 0x11.
- d_req and if_req held continuously, STARVE_MAX=4 -> data wins grants 1-4, fetch wins grant 5, data wins grants 6-9, and the pattern repeats.
- MEM_LAT=3 with a single load -> mem_en high for cycles 1-3, d_valid in cycle 4, and d_rdata equals mem_rdata as sampled at the end of cycle 3.

Source files
------------

// File: rtl/riscv_mem_pkg.sv
// Shared definitions for the arbitrated instruction/data memory port.
package riscv_mem_pkg;

    // Arbiter sequencing states.
    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } arb_state_t;

    // Requester identifiers carried through a transaction.
    localparam logic REQ_IF = 1'b0;
    localparam logic REQ_D  = 1'b1;

    // Default timing and fairness settings.
    localparam int DEF_MEM_LAT    = 1;
    localparam int DEF_STARVE_MAX = 4;

endpackage

// File: rtl/mem_arb_pick.sv
// Priority decision between fetch and data requests: data normally wins,
// but a fetch that has been passed over STARVE_MAX times in a row wins next.
module mem_arb_pick
    import riscv_mem_pkg::*;
#(
    parameter int STARVE_MAX = DEF_STARVE_MAX
) (
    input  logic clk,
    input  logic rst,
    input  logic if_req,
    input  logic d_req,
    input  logic arb_edge,
    output logic winner
);

    logic [3:0] starve_cnt;
    logic       starved;

    assign starved = (starve_cnt == 4'(STARVE_MAX));

    // Data over fetch, unless the fetch side has waited long enough.
    always_comb begin
        winner = REQ_IF;
        if (d_req && !(if_req && starved)) begin
            winner = REQ_D;
        end
    end

    // Count consecutive data wins that left a fetch waiting; saturates.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_cnt <= '0;
        end else if (arb_edge) begin
            if (!if_req || winner == REQ_IF) begin
                starve_cnt <= '0;
            end else if (!starved) begin
                starve_cnt <= starve_cnt + 4'd1;
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port memory between instruction fetch and data access.
// Handshake: a requester holds req (with its addr/data) as a level; it is
// sampled only while idle. gnt is high for the MEM_LAT cycles the access
// owns the memory, and valid pulses for one cycle when the access is done
// (rdata updated for loads/fetches). A requester drops req in its valid
// cycle if it wants nothing more; otherwise the held req is re-arbitrated.
module mem_arbiter
    import riscv_mem_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MEM_LAT    = DEF_MEM_LAT,
    parameter int STARVE_MAX = DEF_STARVE_MAX
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_valid,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_valid,
    output logic              mem_en,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    arb_state_t        state;
    arb_state_t        state_next;
    logic [3:0]        wait_cnt;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_wdata;
    logic              lat_we;
    logic              lat_id;
    logic              any_req;
    logic              arb_edge;
    logic              last_cycle;
    logic              winner;

    assign any_req    = if_req | d_req;
    assign arb_edge   = (state == IDLE);
    assign last_cycle = (state == ACCESS) && (wait_cnt == 4'(MEM_LAT - 1));

    mem_arb_pick #(
        .STARVE_MAX(STARVE_MAX)
    ) u_pick (
        .clk     (clk),
        .rst     (rst),
        .if_req  (if_req),
        .d_req   (d_req),
        .arb_edge(arb_edge),
        .winner  (winner)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state and the memory/grant outputs driven while an access is active.
    always_comb begin
        state_next = state;
        if_gnt     = 1'b0;
        d_gnt      = 1'b0;
        mem_en     = 1'b0;
        mem_wr     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        case (state)
            IDLE: begin
                if (any_req) begin
                    state_next = ACCESS;
                end
            end
            ACCESS: begin
                mem_en    = 1'b1;
                mem_wr    = lat_we;
                mem_addr  = lat_addr;
                mem_wdata = lat_wdata;
                if_gnt    = (lat_id == REQ_IF);
                d_gnt     = (lat_id == REQ_D);
                if (last_cycle) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Capture the winner's transaction and count the access cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt  <= '0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            lat_we    <= 1'b0;
            lat_id    <= REQ_IF;
        end else if (state == IDLE) begin
            wait_cnt <= '0;
            if (any_req) begin
                lat_id <= winner;
                if (winner == REQ_D) begin
                    lat_addr  <= d_addr;
                    lat_we    <= d_we;
                    lat_wdata <= d_wdata;
                end else begin
                    lat_addr  <= if_addr;
                    lat_we    <= 1'b0;
                    lat_wdata <= '0;
                end
            end
        end else if (!last_cycle) begin
            wait_cnt <= wait_cnt + 4'd1;
        end
    end

    // Completion: one-cycle valid to the winner, read data registered for loads/fetches.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            if_valid <= 1'b0;
            d_valid  <= 1'b0;
            if_rdata <= '0;
            d_rdata  <= '0;
        end else begin
            if_valid <= last_cycle && (lat_id == REQ_IF);
            d_valid  <= last_cycle && (lat_id == REQ_D);
            if (last_cycle && !lat_we) begin
                if (lat_id == REQ_IF) begin
                    if_rdata <= mem_rdata;
                end else begin
                    d_rdata <= mem_rdata;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized
// concurrent fetch/data traffic against a transaction-level reference.
module tb_mem_arbiter;
    import riscv_mem_pkg::*;

    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int LAT  = 1;
    localparam int SMAX = 4;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [31:0] cyc = '0;
    always @(posedge clk) cyc <= cyc + 32'd1;

    // ---------------- main DUT (MEM_LAT = 1) ----------------
    logic          if_req, if_gnt, if_valid;
    logic [AW-1:0] if_addr;
    logic [DW-1:0] if_rdata;
    logic          d_req, d_we, d_gnt, d_valid;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata, d_rdata;
    logic          mem_en, mem_wr;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT), .STARVE_MAX(SMAX)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rdata(if_rdata), .if_valid(if_valid),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rdata(d_rdata), .d_valid(d_valid),
        .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    // ---------------- second DUT (MEM_LAT = 3) ----------------
    logic          l3_if_req, l3_if_gnt, l3_if_valid;
    logic [AW-1:0] l3_if_addr;
    logic [DW-1:0] l3_if_rdata;
    logic          l3_d_req, l3_d_we, l3_d_gnt, l3_d_valid;
    logic [AW-1:0] l3_d_addr;
    logic [DW-1:0] l3_d_wdata, l3_d_rdata;
    logic          l3_mem_en, l3_mem_wr;
    logic [AW-1:0] l3_mem_addr;
    logic [DW-1:0] l3_mem_wdata, l3_mem_rdata;

    // Changes every cycle so the sampling cycle is identifiable.
    assign l3_mem_rdata = 32'hA500_0000 ^ cyc;

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(3), .STARVE_MAX(SMAX)) dut3 (
        .clk(clk), .rst(rst),
        .if_req(l3_if_req), .if_addr(l3_if_addr), .if_gnt(l3_if_gnt), .if_rdata(l3_if_rdata), .if_valid(l3_if_valid),
        .d_req(l3_d_req), .d_we(l3_d_we), .d_addr(l3_d_addr), .d_wdata(l3_d_wdata),
        .d_gnt(l3_d_gnt), .d_rdata(l3_d_rdata), .d_valid(l3_d_valid),
        .mem_en(l3_mem_en), .mem_wr(l3_mem_wr), .mem_addr(l3_mem_addr), .mem_wdata(l3_mem_wdata),
        .mem_rdata(l3_mem_rdata)
    );

    // ---------------- memory behind the main DUT ----------------
    function automatic logic [31:0] init_word(input int idx);
        if (idx == 0)  return 32'h0050_0093;
        if (idx == 32) return 32'h0000_0011;
        return 32'h5A5A_0000 ^ (32'(idx) * 32'h0101_0101);
    endfunction

    logic [31:0] mem_arr [64];
    logic [63:0] mem_set = '0;
    always @(posedge clk) begin
        if (mem_en && mem_wr) begin
            mem_arr[mem_addr[7:2]] <= mem_wdata;
            mem_set[mem_addr[7:2]] <= 1'b1;
        end
    end
    assign mem_rdata = mem_set[mem_addr[7:2]] ? mem_arr[mem_addr[7:2]] : init_word(int'(mem_addr[7:2]));

    // ---------------- checking helpers ----------------
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Transaction timeline from the rules: an idle edge with a request starts
    // an access of LAT cycles, then a one-cycle completion. Expected read data
    // is pushed when the transaction is accepted.
    int          m_busy = 0;
    int          m_starve = 0;
    bit          m_is_data = 0, m_we = 0, m_vif = 0, m_vd = 0;
    logic [31:0] m_addr = '0, m_wdata = '0, m_last_d = '0;
    logic [31:0] ref_mem [64];
    bit          ref_ready = 0;
    logic [DW-1:0] exp_if_q[$];
    logic [DW-1:0] exp_d_q[$];

    always @(posedge clk or posedge rst) begin
        bit d_wins;
        if (!ref_ready) begin
            for (int i = 0; i < 64; i++) ref_mem[i] = init_word(i);
            ref_ready = 1;
        end
        if (rst) begin
            m_busy = 0; m_starve = 0; m_vif = 0; m_vd = 0; m_last_d = '0;
            m_is_data = 0; m_we = 0; m_addr = '0; m_wdata = '0;
            exp_if_q.delete();
            exp_d_q.delete();
        end else begin
            m_vif = 0;
            m_vd  = 0;
            if (m_busy > 0) begin
                m_busy--;
                if (m_busy == 0) begin
                    if (m_is_data) m_vd = 1; else m_vif = 1;
                end
            end else if (if_req || d_req) begin
                d_wins = d_req && !(if_req && m_starve == SMAX);
                if (if_req && d_wins) m_starve = (m_starve < SMAX) ? m_starve + 1 : SMAX;
                else m_starve = 0;
                m_busy    = LAT;
                m_is_data = d_wins;
                if (d_wins) begin
                    m_addr  = d_addr;
                    m_we    = d_we;
                    m_wdata = d_wdata;
                    if (d_we) begin
                        ref_mem[int'(d_addr[7:2])] = d_wdata;
                    end else begin
                        m_last_d = ref_mem[int'(d_addr[7:2])];
                    end
                    exp_d_q.push_back(m_last_d);
                end else begin
                    m_addr  = if_addr;
                    m_we    = 0;
                    m_wdata = '0;
                    exp_if_q.push_back(ref_mem[int'(if_addr[7:2])]);
                end
            end else begin
                m_starve = 0;
            end
        end
    end

    // ---------------- monitor / scoreboard ----------------
    logic [31:0] hold_if = '0, hold_d = '0;
    logic        prev_any = 1'b0;
    bit          log_en = 0;
    logic        grant_log[$];
    int          wr_cycles = 0;

    always @(posedge clk) begin
        logic acc;
        #1;
        if (rst) begin
            hold_if  = '0;
            hold_d   = '0;
            prev_any = 1'b0;
            chk("rst_outputs", |{if_gnt, d_gnt, if_valid, d_valid, mem_en, mem_wr, if_rdata, d_rdata}, 0);
        end else begin
            acc = (m_busy > 0);
            chk("if_gnt", if_gnt, acc && !m_is_data);
            chk("d_gnt", d_gnt, acc && m_is_data);
            chk("gnt_exclusive", if_gnt & d_gnt, 0);
            chk("mem_en", mem_en, acc);
            chk("mem_wr", mem_wr, acc && m_we);
            if (acc) begin
                chk("mem_addr", mem_addr, m_addr);
                chk("mem_wdata", mem_wdata, m_wdata);
            end
            chk("if_valid", if_valid, m_vif);
            chk("d_valid", d_valid, m_vd);
            if (if_valid) begin
                if (exp_if_q.size() == 0) chk("if_scoreboard_empty", 1, 0);
                else hold_if = exp_if_q.pop_front();
            end
            if (d_valid) begin
                if (exp_d_q.size() == 0) chk("d_scoreboard_empty", 1, 0);
                else hold_d = exp_d_q.pop_front();
            end
            chk("if_rdata", if_rdata, hold_if);
            chk("d_rdata", d_rdata, hold_d);
            if (log_en && (if_gnt || d_gnt) && !prev_any) grant_log.push_back(d_gnt);
            if (mem_wr) wr_cycles++;
            prev_any = if_gnt || d_gnt;
        end
    end

    // ---------------- driver tasks (entered and left at a negedge) ----------------
    task automatic fetch_txn(input logic [31:0] addr);
        int n = 0;
        if_req  = 1'b1;
        if_addr = addr;
        do begin @(negedge clk); n++; end while (!if_valid && n < 40);
        chk("if_valid_wait", if_valid, 1);
        if_req = 1'b0;
    endtask

    task automatic data_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
        int n = 0;
        d_req   = 1'b1;
        d_we    = we;
        d_addr  = addr;
        d_wdata = wdata;
        do begin @(negedge clk); n++; end while (!d_valid && n < 40);
        chk("d_valid_wait", d_valid, 1);
        d_req = 1'b0;
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] cb;
        int n;
        if_req = 0; if_addr = '0;
        d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0;
        l3_if_req = 0; l3_if_addr = '0;
        l3_d_req = 0; l3_d_we = 0; l3_d_addr = '0; l3_d_wdata = '0;

        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Reset hitting the first cycle of a data access.
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h2000;
        @(negedge clk);
        d_req = 1'b0;
        chk("pre_rst_d_gnt", d_gnt, 1);
        #2 rst = 1'b1;
        #1;
        chk("rst_mem_en", mem_en, 0);
        chk("rst_d_gnt", d_gnt, 0);
        chk("rst_d_valid", d_valid, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (4) begin
            @(negedge clk);
            chk("idle_after_rst", |{if_gnt, d_gnt, if_valid, d_valid, mem_en, mem_wr,
                                    if_rdata, d_rdata, mem_addr, mem_wdata}, 0);
        end

        // Single fetch.
        fetch_txn(32'h100);
        chk("fetch_rdata", if_rdata, 32'h0050_0093);
        repeat (2) @(negedge clk);

        // Simultaneous fetch and load: data first, then fetch.
        grant_log.delete();
        log_en = 1;
        fork
            fetch_txn(32'h100);
            data_txn(1'b0, 32'h2000, 32'h0);
        join
        log_en = 0;
        chk("both_grant_count", grant_log.size(), 2);
        if (grant_log.size() == 2) begin
            chk("both_first_is_data", grant_log[0], 1);
            chk("both_second_is_fetch", grant_log[1], 0);
        end
        repeat (2) @(negedge clk);

        // Load 0x11, then a store that must leave d_rdata alone.
        data_txn(1'b0, 32'h80, 32'h0);
        chk("load_0x80", d_rdata, 32'h11);
        wr_cycles = 0;
        data_txn(1'b1, 32'h40, 32'hDEAD_BEEF);
        repeat (2) @(negedge clk);
        chk("store_keeps_rdata", d_rdata, 32'h11);
        chk("store_wr_cycles", wr_cycles, 1);
        data_txn(1'b0, 32'h40, 32'h0);
        chk("store_readback", d_rdata, 32'hDEAD_BEEF);
        repeat (2) @(negedge clk);

        // Continuous contention: fetch wins every (SMAX+1)th grant.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        grant_log.delete();
        log_en = 1;
        if_req = 1'b1; if_addr = 32'h100;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h2000;
        n = 0;
        while (grant_log.size() < 10 && n < 100) begin @(negedge clk); n++; end
        if_req = 1'b0;
        d_req  = 1'b0;
        log_en = 0;
        chk("starve_grant_count", grant_log.size(), 10);
        for (int i = 0; i < 10 && i < grant_log.size(); i++)
            chk($sformatf("starve_grant_%0d", i + 1), grant_log[i], ((i + 1) % (SMAX + 1) == 0) ? 0 : 1);
        repeat (6) @(negedge clk);

        // Randomized concurrent traffic.
        fork
            begin
                for (int i = 0; i < 60; i++) begin
                    repeat ($urandom_range(0, 3)) @(negedge clk);
                    fetch_txn($urandom());
                end
            end
            begin
                for (int j = 0; j < 60; j++) begin
                    repeat ($urandom_range(0, 3)) @(negedge clk);
                    data_txn(1'($urandom_range(0, 1)), $urandom(), $urandom());
                end
            end
        join
        repeat (5) @(negedge clk);
        chk("if_queue_drained", exp_if_q.size(), 0);
        chk("d_queue_drained", exp_d_q.size(), 0);

        // MEM_LAT = 3: single load timing and sample point.
        l3_d_req = 1'b1; l3_d_we = 1'b0; l3_d_addr = 32'h44;
        cb = cyc;
        @(negedge clk);
        l3_d_req = 1'b0;
        chk("l3_c1_mem_en", l3_mem_en, 1);
        chk("l3_c1_d_gnt", l3_d_gnt, 1);
        chk("l3_c1_mem_addr", l3_mem_addr, 32'h44);
        @(negedge clk);
        chk("l3_c2_mem_en", l3_mem_en, 1);
        chk("l3_c2_d_valid", l3_d_valid, 0);
        @(negedge clk);
        chk("l3_c3_mem_en", l3_mem_en, 1);
        chk("l3_c3_d_valid", l3_d_valid, 0);
        @(negedge clk);
        chk("l3_c4_mem_en", l3_mem_en, 0);
        chk("l3_c4_d_valid", l3_d_valid, 1);
        chk("l3_c4_d_rdata", l3_d_rdata, 32'hA500_0000 ^ (cb + 32'd3));
        @(negedge clk);
        chk("l3_c5_d_valid", l3_d_valid, 0);
        chk("l3_c5_d_rdata_hold", l3_d_rdata, 32'hA500_0000 ^ (cb + 32'd3));
        chk("l3_if_idle", |{l3_if_gnt, l3_if_valid, l3_if_rdata, l3_mem_wr, l3_mem_wdata}, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
